// File: rtl/f_pc_npc_pkg.sv
// f_pc_npc_pkg : shared next-PC op encodings, reset PC and offset helpers (rev 1.0)
`default_nettype none

package f_pc_npc_pkg;

  // Same encodings the D-stage control decoder emits on D_npc_op.
  typedef enum logic [2:0] {
    NPC_SEQ = 3'b000,
    NPC_BR  = 3'b001,
    NPC_J   = 3'b010,
    NPC_JR  = 3'b011,
    NPC_BRL = 3'b100
  } npc_op_e;

  localparam logic [31:0] PC_RESET_VAL = 32'h0000_3000;
  localparam logic [31:0] PC_STEP      = 32'd4;
  localparam logic [31:0] LINK_STEP    = 32'd8;

  // Unused encodings fall back to sequential fetch.
  function automatic npc_op_e decode_op(input logic [2:0] raw);
    case (raw)
      3'b001:  return NPC_BR;
      3'b010:  return NPC_J;
      3'b011:  return NPC_JR;
      3'b100:  return NPC_BRL;
      default: return NPC_SEQ;
    endcase
  endfunction

  function automatic logic is_branch(input npc_op_e op);
    return (op == NPC_BR) || (op == NPC_BRL);
  endfunction

  // Word offset -> sign-extended byte offset.
  function automatic logic [31:0] br_offset(input logic [15:0] imm16);
    return {{14{imm16[15]}}, imm16, 2'b00};
  endfunction

endpackage

`default_nettype wire

// File: rtl/npc_calc.sv
// npc_calc : combinational branch/jump target computation and next-PC select (rev 1.0)
`default_nettype none

module npc_calc
  import f_pc_npc_pkg::*;
(
  input  npc_op_e     op,
  input  logic        cmp_res,
  input  logic [31:0] f_pc,
  input  logic [31:0] d_pc,
  input  logic [15:0] imm16,
  input  logic [25:0] imm26,
  input  logic [31:0] rs_data,
  output logic [31:0] npc,
  output logic        annul
);

  logic [31:0] seq_pc;
  logic [31:0] br_target;
  logic [31:0] j_target;

  assign seq_pc    = f_pc + PC_STEP;
  assign br_target = d_pc + PC_STEP + br_offset(imm16);
  assign j_target  = {d_pc[31:28], imm26, 2'b00};

  // Not-taken fall-through uses F_pc + 4, which is already past the delay slot.
  always_comb begin
    npc   = seq_pc;
    annul = 1'b0;
    case (op)
      NPC_BR: begin
        if (cmp_res) npc = br_target;
      end
      NPC_BRL: begin
        if (cmp_res) npc = br_target;
        else         annul = 1'b1;
      end
      NPC_J:   npc = j_target;
      NPC_JR:  npc = rs_data;
      default: npc = seq_pc;
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/f_pc_npc.sv
// f_pc_npc : fetch PC register, next-PC unit, branch perf counters, JR misalign flag (rev 1.0)
`default_nettype none

module f_pc_npc
  import f_pc_npc_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_VAL,
  parameter int          CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic [2:0]       D_npc_op,
  input  logic             D_cmp_res,
  input  logic [31:0]      D_pc,
  input  logic [15:0]      D_imm16,
  input  logic [25:0]      D_imm26,
  input  logic [31:0]      D_rs_data,
  output logic [31:0]      F_pc,
  output logic [31:0]      D_link,
  output logic             F_annul,
  output logic             jr_misalign,
  output logic [CNT_W-1:0] perf_br_taken,
  output logic [CNT_W-1:0] perf_br_nt
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  npc_op_e     op;
  logic [31:0] calc_npc;
  logic        calc_annul;
  logic        br_op;
  logic        jr_bad;

  assign op     = decode_op(D_npc_op);
  assign br_op  = is_branch(op);
  assign jr_bad = (op == NPC_JR) && (D_rs_data[1:0] != 2'b00);

  npc_calc u_calc (
    .op      (op),
    .cmp_res (D_cmp_res),
    .f_pc    (F_pc),
    .d_pc    (D_pc),
    .imm16   (D_imm16),
    .imm26   (D_imm26),
    .rs_data (D_rs_data),
    .npc     (calc_npc),
    .annul   (calc_annul)
  );

  assign D_link  = D_pc + LINK_STEP;
  // A stalled or resetting pipe must never squash the F/D register.
  assign F_annul = calc_annul & ~stall & ~reset;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      F_pc          <= PC_RESET;
      perf_br_taken <= '0;
      perf_br_nt    <= '0;
      jr_misalign   <= 1'b0;
    end else if (!stall) begin
      F_pc <= calc_npc;
      if (br_op) begin
        if (D_cmp_res) perf_br_taken <= perf_br_taken + CNT_ONE;
        else           perf_br_nt    <= perf_br_nt + CNT_ONE;
      end
      if (jr_bad) jr_misalign <= 1'b1;
    end
  end

endmodule

`default_nettype wire
